mem_responder: RTL and testbench

- Memory-side responder for the multicycle ARM core's single memory port (`MemWrite`, `Adr`, `WriteData`, `ReadData`).
- Serves a unified instruction/data word RAM plus a small memory-mapped I/O window.
- The I/O window contains:
  - a byte transmit FIFO drained over a valid/ready stream,
  - a sticky overflow flag,
  - a cycle counter,
  - a halt flag.
- Sits beside the core at the top level; its output stream feeds a testbench sink or console.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/tx_fifo.sv | 75 +++++++
 rtl/mem_responder.sv | 145 ++++++++++++++
 tb/tb_mem_responder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants and address-decode helper for the memory responder
// and its MMIO window.
package mem_pkg;

    // MMIO register word offsets (Adr[3:2]) within the 16-byte window
    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CYCLES = 2'd2;
    localparam logic [1:0] OFF_HALT   = 2'd3;

    // STATUS register bit positions
    localparam int unsigned ST_FULL      = 0;
    localparam int unsigned ST_EMPTY     = 1;
    localparam int unsigned ST_OVF       = 2;
    localparam int unsigned ST_COUNT_LSB = 8;
    localparam int unsigned ST_COUNT_W   = 4;

    // Compares the 16-byte-aligned part of an address against the window base
    function automatic logic is_mmio(input logic [27:0] adr_hi, input logic [27:0] base_hi);
        return adr_hi == base_hi;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Circular byte FIFO feeding the transmit stream; owns push-accept logic
// so a push into a full FIFO succeeds when a pop happens in the same cycle.
module tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [WIDTH-1:0]           head_o,
    output logic                       drop_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_ok;
    logic             push_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    // Head is forced to zero when empty so discarded contents never leak out
    assign head_o  = empty_o ? '0 : mem_q[rptr_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign drop_o  = push_i && !push_ok;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (pop_ok) begin
            rptr_d = rptr_q + PW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; pointers and count define what is valid
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: word RAM plus MMIO window (TX FIFO, STATUS, CYCLES, HALT).
// Build macro MMIO_CYCLES_EN enables the CYCLES register and its counter.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned MEM_WORDS  = 64,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halted
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   ram_q [MEM_WORDS];
    logic [AW-1:0] ram_idx;
    logic          mmio_sel;
    logic [1:0]    mmio_off;

    logic          wr_tx, wr_status, wr_halt;
    logic          fifo_full, fifo_empty, fifo_drop;
    logic [CW-1:0] fifo_count;

    logic          overflow_q, overflow_d;
    logic          halted_q, halted_d;
    logic [31:0]   cycles_rd;

    logic          unused_c;
    assign unused_c = ^{Adr[1:0], WriteData[31:8]};

    assign mmio_sel = is_mmio(Adr[31:4], MMIO_BASE[31:4]);
    assign mmio_off = Adr[3:2];
    assign ram_idx  = Adr[2 +: AW];

    assign wr_tx     = MemWrite && mmio_sel && (mmio_off == OFF_TXDATA);
    assign wr_status = MemWrite && mmio_sel && (mmio_off == OFF_STATUS);
    assign wr_halt   = MemWrite && mmio_sel && (mmio_off == OFF_HALT);

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (MemWrite && !mmio_sel) begin
            ram_q[ram_idx] <= WriteData;
        end
    end

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk     (clk),
        .rst_ni  (reset),
        .push_i  (wr_tx),
        .data_i  (WriteData[7:0]),
        .pop_i   (tx_ready),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .head_o  (tx_data),
        .drop_o  (fifo_drop)
    );

    assign tx_valid = !fifo_empty;
    assign halted   = halted_q;

    // Overflow set wins over a same-cycle clear
    always_comb begin
        overflow_d = overflow_q;
        halted_d   = halted_q | wr_halt;
        if (wr_status && WriteData[ST_OVF]) begin
            overflow_d = 1'b0;
        end
        if (fifo_drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            halted_q   <= halted_d;
        end
    end

`ifdef MMIO_CYCLES_EN
    logic        wr_cycles;
    logic [31:0] cycles_q, cycles_d;

    assign wr_cycles = MemWrite && mmio_sel && (mmio_off == OFF_CYCLES);

    // Load beats increment; counter freezes once halted and wraps naturally
    always_comb begin
        cycles_d = cycles_q;
        if (wr_cycles) begin
            cycles_d = WriteData;
        end else if (!halted_q) begin
            cycles_d = cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign cycles_rd = cycles_q;
`else
    assign cycles_rd = '0;
`endif

    always_comb begin
        ReadData = '0;
        if (mmio_sel) begin
            case (mmio_off)
                OFF_STATUS: begin
                    ReadData[ST_FULL]  = fifo_full;
                    ReadData[ST_EMPTY] = fifo_empty;
                    ReadData[ST_OVF]   = overflow_q;
                    ReadData[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(fifo_count);
                end
                OFF_CYCLES: ReadData = cycles_rd;
                OFF_HALT:   ReadData = {31'b0, halted_q};
                default:    ReadData = '0;
            endcase
        end else begin
            ReadData = ram_q[ram_idx];
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: RAM/MMIO vector table plus
// hand-written FIFO, counter, halt and reset sequences with a byte scoreboard.
module tb_mem_responder;

    localparam logic [31:0] A_TX = 32'h0000_1000;
    localparam logic [31:0] A_ST = 32'h0000_1004;
    localparam logic [31:0] A_CY = 32'h0000_1008;
    localparam logic [31:0] A_HT = 32'h0000_100C;
`ifdef MMIO_CYCLES_EN
    localparam bit CYC_EN = 1'b1;
`else
    localparam bit CYC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] Adr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wd;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    mem_responder #(
        .MEM_WORDS  (64),
        .FIFO_DEPTH (8),
        .MMIO_BASE  (32'h0000_1000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .Adr       (Adr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive the bus at posedge+1 and let combinational outputs settle
    task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] wd);
        MemWrite  = we;
        Adr       = adr;
        WriteData = wd;
        #4;
    endtask

    // Score any byte transferred at the coming edge, then advance one cycle
    task automatic tick();
        logic [7:0] e;
        if (reset && tx_valid && tx_ready) begin
            if (sb.size() == 0) begin
                check("tx_unexpected", {24'b0, tx_data}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("tx_byte", {24'b0, tx_data}, {24'b0, e});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        tick();
        sb.delete();
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        MemWrite  = 1'b0;
        Adr       = '0;
        WriteData = '0;
        tx_ready  = 1'b0;

        vecs[0]  = '{1'b0, A_ST,         32'h0,         1'b1, 32'h0000_0002};
        vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b0, 32'h0000_0110, 32'h0,         1'b1, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b1, 32'h0000_0014, 32'h1234_5678, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_0114, 32'h0,         1'b1, 32'h1234_5678};
        vecs[6]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF};
        vecs[7]  = '{1'b0, A_TX,         32'h0,         1'b1, 32'h0};
        vecs[8]  = '{1'b0, A_HT,         32'h0,         1'b1, 32'h0};
        vecs[9]  = '{1'b0, 32'h0000_1010, 32'h0,         1'b1, 32'hDEAD_BEEF};
        vecs[10] = '{1'b0, 32'h0000_0012, 32'h0,         1'b1, 32'hDEAD_BEEF};

        @(posedge clk);
        #1;
        do_reset();
        drive(1'b0, A_ST, 32'h0);
        check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("rst_tx_data", {24'b0, tx_data}, 32'h0);
        check("rst_halted", {31'b0, halted}, 32'h0);

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].we, vecs[i].adr, vecs[i].wd);
            if (vecs[i].chk) begin
                check($sformatf("vec%0d", i), ReadData, vecs[i].exp);
            end
            tick();
        end

        // Counter from reset, then load and wrap
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, A_CY, 32'h0);
            check($sformatf("cycles_n%0d", i), ReadData, CYC_EN ? 32'(i) : 32'h0);
            tick();
        end
        drive(1'b1, A_CY, 32'hFFFF_FFFE);
        tick();
        drive(1'b0, A_CY, 32'h0);
        check("cycles_load", ReadData, CYC_EN ? 32'hFFFF_FFFE : 32'h0);
        tick();
        drive(1'b0, A_CY, 32'h0);
        check("cycles_max", ReadData, CYC_EN ? 32'hFFFF_FFFF : 32'h0);
        tick();
        drive(1'b0, A_CY, 32'h0);
        check("cycles_wrap", ReadData, 32'h0);
        tick();

        // Halt freezes the counter; reset releases it
        do_reset();
        drive(1'b1, A_HT, 32'h0);
        check("halt_before", {31'b0, halted}, 32'h0);
        tick();
        drive(1'b0, A_CY, 32'h0);
        check("halt_set", {31'b0, halted}, 32'h1);
        check("halt_cyc0", ReadData, CYC_EN ? 32'h1 : 32'h0);
        tick();
        drive(1'b0, A_CY, 32'h0);
        check("halt_cyc1", ReadData, CYC_EN ? 32'h1 : 32'h0);
        tick();
        drive(1'b0, A_CY, 32'h0);
        tick();
        drive(1'b0, A_CY, 32'h0);
        check("halt_cyc3", ReadData, CYC_EN ? 32'h1 : 32'h0);
        tick();
        drive(1'b0, A_HT, 32'h0);
        check("halt_read", ReadData, 32'h1);
        tick();
        do_reset();
        drive(1'b0, A_CY, 32'h0);
        check("halt_clr", {31'b0, halted}, 32'h0);
        check("halt_cyc_clr", ReadData, 32'h0);
        tick();

        // Fill past full with the sink stalled, then drain
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, A_TX, 32'(8'h41 + i));
            if (i < 8) sb.push_back(8'(8'h41 + i));
            tick();
        end
        drive(1'b0, A_ST, 32'h0);
        check("fill_status", ReadData, 32'h0000_0805);
        check("fill_head", {24'b0, tx_data}, 32'h41);
        tick();
        drive(1'b0, A_ST, 32'h0);
        check("fill_head_stable", {24'b0, tx_data}, 32'h41);
        tx_ready = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, A_ST, 32'h0);
            tick();
        end
        drive(1'b0, A_ST, 32'h0);
        check("drain_sb", 32'(sb.size()), 32'h0);
        check("drain_valid", {31'b0, tx_valid}, 32'h0);
        check("drain_status", ReadData, 32'h0000_0006);
        tick();
        drive(1'b1, A_ST, 32'h0000_0004);
        tick();
        drive(1'b0, A_ST, 32'h0);
        check("ovf_clear", ReadData, 32'h0000_0002);
        tick();

        // Push into a full FIFO while it pops
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, A_TX, 32'(8'h50 + i));
            sb.push_back(8'(8'h50 + i));
            tick();
        end
        drive(1'b0, A_ST, 32'h0);
        check("sim_full", ReadData, 32'h0000_0801);
        tx_ready = 1'b1;
        drive(1'b1, A_TX, 32'h0000_005A);
        sb.push_back(8'h5A);
        tick();
        tx_ready = 1'b0;
        drive(1'b0, A_ST, 32'h0);
        check("sim_status", ReadData, 32'h0000_0801);
        tick();
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, A_ST, 32'h0);
            tick();
        end
        drive(1'b0, A_ST, 32'h0);
        check("sim_sb", 32'(sb.size()), 32'h0);
        check("sim_empty", ReadData, 32'h0000_0002);
        tick();

        // Reset with bytes queued and overflow set
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, A_TX, 32'(8'h60 + i));
            if (i < 8) sb.push_back(8'(8'h60 + i));
            tick();
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, A_ST, 32'h0);
            tick();
        end
        tx_ready = 1'b0;
        drive(1'b0, A_ST, 32'h0);
        check("mid_status", ReadData, 32'h0000_0304);
        tick();
        reset    = 1'b0;
        tx_ready = 1'b1;
        drive(1'b1, A_TX, 32'h0000_0077);
        tick();
        sb.delete();
        reset    = 1'b1;
        tx_ready = 1'b0;
        drive(1'b0, A_ST, 32'h0);
        check("mid_valid", {31'b0, tx_valid}, 32'h0);
        check("mid_data", {24'b0, tx_data}, 32'h0);
        check("mid_rst_status", ReadData, 32'h0000_0002);
        tick();
        drive(1'b0, 32'h0000_0010, 32'h0);
        check("ram_survives", ReadData, 32'hDEAD_BEEF);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
